// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU/immediate encodings and the
// bit layout of the packed control word carried into the execute stage.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Ctrl_E = {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
    localparam int CTRL_W              = 10;
    localparam int CTRL_REG_WRITE      = 9;
    localparam int CTRL_RESULT_SRC_LSB = 7;
    localparam int CTRL_MEM_WRITE      = 6;
    localparam int CTRL_JUMP           = 5;
    localparam int CTRL_BRANCH         = 4;
    localparam int CTRL_ALU_LSB        = 1;
    localparam int CTRL_ALU_SRC        = 0;

    function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] instr,
                                                   input imm_src_e        src);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (src)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard-unit taps and the
// ID/EX register outputs. The slave side is the decode stage itself.
interface decode_cycle_if;
    import riscv_pkg::*;

    logic                  Flush_E;
    logic [XLEN-1:0]       Instr_D;
    logic [XLEN-1:0]       PC_D;
    logic [XLEN-1:0]       PCPlus4_D;
    logic                  RegWrite_W;
    logic [REG_ADDR_W-1:0] RD_W;
    logic [XLEN-1:0]       Result_W;

    logic [REG_ADDR_W-1:0] RS1_D;
    logic [REG_ADDR_W-1:0] RS2_D;
    logic [CTRL_W-1:0]     Ctrl_E;
    logic [XLEN-1:0]       RD1_E;
    logic [XLEN-1:0]       RD2_E;
    logic [XLEN-1:0]       Imm_Ext_E;
    logic [XLEN-1:0]       PC_E;
    logic [XLEN-1:0]       PCPlus4_E;
    logic [REG_ADDR_W-1:0] RS1_E;
    logic [REG_ADDR_W-1:0] RS2_E;
    logic [REG_ADDR_W-1:0] RD_E;

    modport master (
        output Flush_E, Instr_D, PC_D, PCPlus4_D, RegWrite_W, RD_W, Result_W,
        input  RS1_D, RS2_D, Ctrl_E, RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E,
               RS1_E, RS2_E, RD_E
    );

    modport slave (
        input  Flush_E, Instr_D, PC_D, PCPlus4_D, RegWrite_W, RD_W, Result_W,
        output RS1_D, RS2_D, Ctrl_E, RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E,
               RS1_E, RS2_E, RD_E
    );

endinterface

// File: rtl/reg_file.sv
// 32x32 register file, two async read ports and one write port. x0 is hard
// zero; a same-cycle write to a register being read is forwarded to the reader.
module reg_file
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] a1,
    input  logic [REG_ADDR_W-1:0] a2,
    input  logic [REG_ADDR_W-1:0] a3,
    input  logic [XLEN-1:0]       wd,
    output logic [XLEN-1:0]       rd1,
    output logic [XLEN-1:0]       rd2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (a3 != '0)) begin
            regs[a3] <= wd;
        end
    end

    // A non-zero read address that matches a3 implies a3 != 0, so the bypass
    // never leaks a write aimed at x0.
    always_comb begin
        rd1 = regs[a1];
        if (a1 == '0) begin
            rd1 = '0;
        end else if (we && (a3 == a1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[a2];
        if (a2 == '0) begin
            rd2 = '0;
        end else if (we && (a3 == a2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate generation, register-file
// read and the ID/EX pipeline register (flushable to a bubble).
module decode_cycle
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_b5;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    assign opcode    = bus.Instr_D[6:0];
    assign rd        = bus.Instr_D[11:7];
    assign funct3    = bus.Instr_D[14:12];
    assign rs1       = bus.Instr_D[19:15];
    assign rs2       = bus.Instr_D[24:20];
    assign funct7_b5 = bus.Instr_D[30];

    assign bus.RS1_D = rs1;
    assign bus.RS2_D = rs2;

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (bus.RegWrite_W),
        .a1  (rs1),
        .a2  (rs2),
        .a3  (bus.RD_W),
        .wd  (bus.Result_W),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        arith;
    logic        imm_en;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_ctrl;

    always_comb begin
        reg_write  = 1'b0;
        result_src = RES_ALU;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        arith      = 1'b0;
        imm_en     = 1'b0;
        imm_src    = IMM_I;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                alu_src    = 1'b1;
                imm_en     = 1'b1;
                imm_src    = IMM_I;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_en    = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = 1'b1;
                arith     = 1'b1;
            end
            OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                arith     = 1'b1;
                imm_en    = 1'b1;
                imm_src   = IMM_I;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                imm_en  = 1'b1;
                imm_src = IMM_B;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                result_src = RES_PC4;
                jump       = 1'b1;
                imm_en     = 1'b1;
                imm_src    = IMM_J;
            end
            default: begin
            end
        endcase
    end

    // Subtract only for R-type: in I-type the funct7 position is immediate data.
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (branch) begin
            alu_ctrl = ALU_SUB;
        end else if (arith) begin
            case (funct3)
                3'b000:  alu_ctrl = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm_ext;

    always_comb begin
        ctrl                                  = '0;
        ctrl[CTRL_REG_WRITE]                  = reg_write;
        ctrl[CTRL_RESULT_SRC_LSB +: 2]        = result_src;
        ctrl[CTRL_MEM_WRITE]                  = mem_write;
        ctrl[CTRL_JUMP]                       = jump;
        ctrl[CTRL_BRANCH]                     = branch;
        ctrl[CTRL_ALU_LSB +: 3]               = alu_ctrl;
        ctrl[CTRL_ALU_SRC]                    = alu_src;
    end

    assign imm_ext = imm_en ? imm_extend(bus.Instr_D, imm_src) : '0;

    // ---- ID/EX boundary ----
    logic [CTRL_W-1:0]     ctrl_p1;
    logic [XLEN-1:0]       rd1_p1;
    logic [XLEN-1:0]       rd2_p1;
    logic [XLEN-1:0]       imm_p1;
    logic [XLEN-1:0]       pc_p1;
    logic [XLEN-1:0]       pc4_p1;
    logic [REG_ADDR_W-1:0] rs1_p1;
    logic [REG_ADDR_W-1:0] rs2_p1;
    logic [REG_ADDR_W-1:0] rd_p1;

    always_ff @(posedge clk) begin
        if (rst || bus.Flush_E) begin
            ctrl_p1 <= '0;
            rd1_p1  <= '0;
            rd2_p1  <= '0;
            imm_p1  <= '0;
            pc_p1   <= '0;
            pc4_p1  <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            rd_p1   <= '0;
        end else begin
            ctrl_p1 <= ctrl;
            rd1_p1  <= rd1;
            rd2_p1  <= rd2;
            imm_p1  <= imm_ext;
            pc_p1   <= bus.PC_D;
            pc4_p1  <= bus.PCPlus4_D;
            rs1_p1  <= rs1;
            rs2_p1  <= rs2;
            rd_p1   <= rd;
        end
    end

    assign bus.Ctrl_E    = ctrl_p1;
    assign bus.RD1_E     = rd1_p1;
    assign bus.RD2_E     = rd2_p1;
    assign bus.Imm_Ext_E = imm_p1;
    assign bus.PC_E      = pc_p1;
    assign bus.PCPlus4_E = pc4_p1;
    assign bus.RS1_E     = rs1_p1;
    assign bus.RS2_E     = rs2_p1;
    assign bus.RD_E      = rd_p1;

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Flush_E  in  1  clears the ID/EX register to a bubble on the next edge.
REQ-005 Instr_D  in  32  instruction from the IF/ID register.
REQ-006 PC_D  in  32  PC of Instr_D.
REQ-007 PCPlus4_D  in  32  PC_D+4.
REQ-008 RegWrite_W  in  1  writeback enable.
REQ-009 RD_W  in  5  writeback destination register.
REQ-010 Result_W  in  32  writeback data.
REQ-011 RS1_D  out  5  Instr_D[19:15], combinational, for the hazard unit.
REQ-012 RS2_D  out  5  Instr_D[24:20], combinational, for the hazard unit.
REQ-013 Ctrl_E  out  10  registered {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}.
REQ-014 RD1_E  out  32  registered rs1 read data.
REQ-015 RD2_E  out  32  registered rs2 read data.
REQ-016 Imm_Ext_E  out  32  registered sign-extended immediate.
REQ-017 PC_E  out  32  registered PC_D.
REQ-018 PCPlus4_E  out  32  registered PCPlus4_D.
REQ-019 RS1_E  out  5  registered RS1_D.
REQ-020 RS2_E  out  5  registered RS2_D.
REQ-021 RD_E  out  5  registered Instr_D[11:7].

Function
REQ-022 Register file: 32x32; x0 reads 0 and ignores writes; write on the rising edge when RegWrite_W=1 and RD_W!=0.
REQ-023 Same-cycle write/read bypass: when RegWrite_W=1, RD_W!=0 and RD_W equals rs1/rs2, the corresponding read data is Result_W.
REQ-024 Opcode decode, fields {RegWrite,ResultSrc,MemWrite,Jump,Branch,ALUSrc,ImmSrc}: lw 0000011 -> {1,01,0,0,0,1,I}; sw 0100011 -> {0,00,1,0,0,1,S}; R 0110011 -> {1,00,0,0,0,0,-}; I-ALU 0010011 -> {1,00,0,0,0,1,I}; beq 1100011 -> {0,00,0,0,1,0,B}; jal 1101111 -> {1,10,0,1,0,0,J}.
REQ-025 Any other opcode, including Instr_D=0: all control bits 0 and Imm_Ext 0.
REQ-026 ALUControl encodings: add=000, sub=001, and=010, or=011, slt=101.
REQ-027 ALUControl: lw/sw/jal -> add; beq -> sub; R/I-ALU by funct3: 000 -> add, or sub only for R with funct7[5]=1; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
REQ-028 Immediate I: sext(i[31:20]); S: sext({i[31:25],i[11:7]}); B: sext({i[31],i[7],i[30:25],i[11:8],0}); J: sext({i[31],i[19:12],i[20],i[30:21],0}).
REQ-029 Latency: every _E output reflects the _D inputs one clock after capture; no stall input; the ID/EX register loads every cycle.
REQ-030 Flush_E=1: the ID/EX register loads all zeros (bubble); the register-file write still occurs.
REQ-031 Simultaneous rst and Flush_E: rst dominates; the result is identical (all zeros).

Reset
REQ-032 rst=1 at a rising edge: all ID/EX outputs and all 32 registers become 0; RegWrite_W in that cycle is ignored.
REQ-033 Mid-operation reset discards in-flight state; the first post-reset edge decodes Instr_D normally.

Structure
REQ-034 Shared package riscv_pkg holds the opcode constants, ALUControl encodings, ImmSrc encodings (I=00, S=01, B=10, J=11) and Ctrl_E bit positions.
REQ-035 Sub-module reg_file (2 read ports, 1 write port, bypass, x0 rule); decode logic and the ID/EX register stay in decode_cycle.

Verification
REQ-036 Instr_D=0x00500093 (addi x1,x0,5), PC_D=0x10 -> next edge: Ctrl_E RegWrite=1, ALUSrc=1, ALUControl=000; Imm_Ext_E=5; RD_E=1; PC_E=0x10.
REQ-037 Write x1=7, x2=3 via W port; Instr_D=0x402081B3 (sub x3,x1,x2) -> RD1_E=7, RD2_E=3, ALUControl=001, RD_E=3.
REQ-038 Instr_D=0xFE208EE3 (beq x1,x2,-4) -> Branch=1, ALUControl=001, Imm_Ext_E=0xFFFFFFFC; Instr_D=0x0020A423 (sw) -> MemWrite=1, Imm_Ext_E=8.
REQ-039 Bypass: RegWrite_W=1, RD_W=1, Result_W=0xABCD in the same cycle as a read of x1 -> RD1_E=0xABCD; write to x0 -> x0 still reads 0.
REQ-040 Flush_E=1 with a valid lw in decode -> all _E outputs 0; rst=1 mid-stream -> all outputs 0 and x1 reads 0 afterwards.
